// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shifter: operation codes and FSM state encoding.
package shift_pkg;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: shifts A by 0..MAX_STEP bits using the selected op.
// For SRA the fill bit comes from the sign latched at accept, not from A's current MSB.
module shift_step
  import shift_pkg::*;
#(
  parameter  int WIDTH    = 32,
  parameter  int MAX_STEP = 4,
  localparam int AW       = $clog2(MAX_STEP) + 1,
  localparam int SW       = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] A,
  input  logic [AW-1:0]    amt,
  input  logic [1:0]       op,
  input  logic             sign,
  output logic [WIDTH-1:0] B
);

  logic [WIDTH-1:0] srl_val;
  logic [WIDTH-1:0] fill_mask;
  logic [SW-1:0]    lamt;

  // Shift A by amt; ROR's left part is shifted by WIDTH when amt=0, which yields zero.
  always_comb begin
    srl_val   = A >> amt;
    fill_mask = ~({WIDTH{1'b1}} >> amt);
    lamt      = SW'(WIDTH) - SW'(amt);
    B         = A;
    case (op)
      OP_SLL:  B = A << amt;
      OP_SRL:  B = srl_val;
      OP_SRA:  B = srl_val | (fill_mask & {WIDTH{sign}});
      OP_ROR:  B = srl_val | (A << lamt);
      default: B = A;
    endcase
  end

endmodule

// File: rtl/shift_iter_unit.sv
// Multi-cycle shifter for the ALU shift path: SLL/SRL/SRA/ROR by a variable amount,
// applying at most MAX_STEP bits per BUSY cycle, with valid/ready ports on both sides.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for an operand; in_ready=1
// S_BUSY | shifting by min(rem, MAX_STEP) per cycle until rem reaches 0
// S_DONE | result held on out_data/out_zero until out_ready; may reload
module shift_iter_unit
  import shift_pkg::*;
#(
  parameter  int WIDTH    = 32,
  parameter  int MAX_STEP = 4,
  localparam int SHW      = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  localparam int AW = $clog2(MAX_STEP) + 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       op_q, op_d;
  logic             sign_q, sign_d;
  logic [SHW-1:0]   rem_q, rem_d;
  logic             zero_q, zero_d;

  logic             accept;
  logic [AW-1:0]    step_amt;
  logic [SHW-1:0]   rem_step;
  logic             last_step;
  logic [WIDTH-1:0] step_out;

  shift_step #(
    .WIDTH    (WIDTH),
    .MAX_STEP (MAX_STEP)
  ) u_step (
    .A    (data_q),
    .amt  (step_amt),
    .op   (op_q),
    .sign (sign_q),
    .B    (step_out)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers; out_zero is captured alongside the data it describes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      op_q   <= OP_SLL;
      sign_q <= 1'b0;
      rem_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      data_q <= data_d;
      op_q   <= op_d;
      sign_q <= sign_d;
      rem_q  <= rem_d;
      zero_q <= zero_d;
    end
  end

  // Step size for this cycle and the remaining amount after it.
  always_comb begin
    if (rem_q > SHW'(MAX_STEP)) begin
      step_amt = AW'(MAX_STEP);
    end else begin
      step_amt = rem_q[AW-1:0];
    end
    rem_step  = rem_q - SHW'(step_amt);
    last_step = (rem_step == '0);
  end

  // Handshake outputs; a DONE result can hand off and reload in the same cycle.
  always_comb begin
    in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    out_valid = (state_q == S_DONE);
    accept    = in_valid && in_ready;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = (in_shamt == '0) ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        if (last_step) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (accept) begin
          state_d = (in_shamt == '0) ? S_DONE : S_BUSY;
        end else if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture on accept, one shift step per BUSY cycle, otherwise hold.
  always_comb begin
    data_d = data_q;
    op_d   = op_q;
    sign_d = sign_q;
    rem_d  = rem_q;
    if (accept) begin
      data_d = in_data;
      op_d   = in_op;
      sign_d = in_data[WIDTH-1];
      rem_d  = in_shamt;
    end else if (state_q == S_BUSY) begin
      data_d = step_out;
      rem_d  = rem_step;
    end
    zero_d = (data_d == '0);
  end

  assign out_data = data_q;
  assign out_zero = zero_q;

endmodule

// File: tb/tb_shift_iter_unit.sv
// Scoreboard bench for shift_iter_unit, run in parallel for MAX_STEP = 1, 4 and 16.
module tb_shift_iter_unit;
  import shift_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp    = 0;
  int n_bad    = 0;
  int done_cnt = 0;

  typedef struct {
    logic [W-1:0] d;
    logic         z;
    int           lat;
    int           acc;
  } exp_t;

  // Whole-amount reference shift.
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] a, input int s,
                                             input logic [1:0] o);
    logic [W-1:0] r;
    case (o)
      OP_SLL:  r = a << s;
      OP_SRL:  r = a >> s;
      OP_SRA:  r = W'($signed(a) >>> s);
      default: r = (s == 0) ? a : ((a >> s) | (a << (W - s)));
    endcase
    return r;
  endfunction

  function automatic void chk(input string nm, input int g, input logic [W-1:0] act,
                              input logic [W-1:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s (inst %0d): got %h expected %h", nm, g, act, expv);
    end
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_ms
    localparam int MS = (gi == 0) ? 1 : (gi == 1) ? 4 : 16;

    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_zero;
    logic         out_ready = 1'b1;
    logic [W-1:0] in_data, out_data;
    logic [4:0]   in_shamt;
    logic [1:0]   in_op;
    int           cyc      = 0;
    int           rdy_mode = 0;
    bit           seen     = 1'b0;
    exp_t         q[$];

    shift_iter_unit #(.WIDTH(W), .MAX_STEP(MS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_shamt  (in_shamt),
      .in_op     (in_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_zero  (out_zero)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(3) != 0);
        default: out_ready = 1'b0;
      endcase
    end

    // Monitor: compares every valid cycle against the queue head, checks latency once per result.
    always @(negedge clk) begin
      if (rst_n === 1'b1) begin
        if (out_valid === 1'b1) begin
          if (q.size() == 0) begin
            chk("spurious_out_valid", gi, W'(out_valid), W'(0));
          end else begin
            if (!seen) begin
              chk("latency", gi, W'(cyc - q[0].acc), W'(q[0].lat));
              seen = 1'b1;
            end
            chk("out_data", gi, out_data, q[0].d);
            chk("out_zero", gi, W'(out_zero), W'(q[0].z));
            chk("in_ready_done", gi, W'(in_ready), W'(out_ready));
            if (out_ready) begin
              void'(q.pop_front());
              seen = 1'b0;
            end
          end
        end else begin
          chk("in_ready_idle_busy", gi, W'(in_ready), W'(q.size() == 0));
        end
      end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [W-1:0] a, input int s, input logic [1:0] o);
      bit   ok;
      exp_t e;
      ok       = 1'b0;
      in_valid = 1'b1;
      in_data  = a;
      in_shamt = 5'(s);
      in_op    = o;
      for (int n = 0; n < 400 && !ok; n++) begin
        @(negedge clk);
        ok = (in_ready === 1'b1);
      end
      if (!ok) begin
        chk("accept_timeout", gi, W'(ok), W'(1));
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      e.d   = ref_shift(a, s, o);
      e.z   = (e.d == '0);
      e.lat = (s + MS - 1) / MS;
      e.acc = cyc;
      q.push_back(e);
      in_valid = 1'b0;
      in_data  = $urandom;
      in_shamt = 5'($urandom);
      in_op    = 2'($urandom);
    endtask

    task automatic drain();
      for (int i = 0; i < 400 && q.size() != 0; i++) @(negedge clk);
      if (q.size() != 0) chk("drain_timeout", gi, W'(q.size()), W'(0));
    endtask

    initial begin
      int gap;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      in_shamt = '0;
      in_op    = OP_SLL;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", gi, W'(out_valid), W'(0));
      chk("rst_out_data", gi, out_data, W'(0));
      chk("rst_out_zero", gi, W'(out_zero), W'(1));
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset during BUSY abandons the operation.
      send(32'hF000_0000, 16, OP_SRA);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      q.delete();
      seen = 1'b0;
      @(negedge clk);
      chk("midrst_out_valid", gi, W'(out_valid), W'(0));
      chk("midrst_out_data", gi, out_data, W'(0));
      chk("midrst_out_zero", gi, W'(out_zero), W'(1));
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("release_in_ready", gi, W'(in_ready), W'(1));
      @(posedge clk);
      #1;

      send(32'h8000_0000, 31, OP_SRA);
      send(32'h0000_0001, 1, OP_ROR);
      send(32'h1234_5678, 0, OP_SLL);
      send(32'h0000_00F0, 8, OP_SRL);
      drain();

      // Hold the result under back-pressure, then release with a waiting operand.
      rdy_mode = 2;
      @(posedge clk);
      #1;
      send(32'h0000_0003, 4, OP_SLL);
      fork
        send(32'hDEAD_BEEF, 7, OP_ROR);
        begin
          for (int i = 0; i < 100 && out_valid !== 1'b1; i++) @(negedge clk);
          repeat (5) @(negedge clk);
          rdy_mode = 0;
        end
      join

      // Sweep every op and shift amount with random data, gaps and back-pressure.
      rdy_mode = 1;
      for (int o = 0; o < 4; o++) begin
        for (int s = 0; s < 32; s++) begin
          gap = $urandom_range(2);
          repeat (gap) begin
            @(posedge clk);
            #1;
          end
          send($urandom, s, 2'(o));
        end
      end
      drain();
      rdy_mode = 0;
      done_cnt++;
    end
  end

  initial begin
    for (int i = 0; i < 60000 && done_cnt < 3; i++) @(posedge clk);
    if (done_cnt < 3) chk("global_timeout", -1, W'(done_cnt), W'(3));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
